// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory slave between the CPU instruction and data request ports.
// Latency: a request is forwarded in its arrival cycle when the slave is idle; the response returns combinationally.
// Backpressure: a losing or busy-time request is held in a per-port buffer and issued one cycle after the response.
module mem_arbiter #(
  parameter int RR_EN   = 0,
  parameter int TIMEOUT = 0,
  parameter int TCNT_W  = 16
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        i_valid,
  input  logic        i_instr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_valid,
  input  logic        d_instr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // The watchdog compares against TIMEOUT-1 because the counter starts at 0 in the first BUSY cycle.
  localparam bit                WD_EN = (TIMEOUT > 0);
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t             state, state_nxt;
  req_t               i_live, d_live, i_buf, d_buf, i_sel, d_sel, fwd;
  logic               pend_i, pend_d;
  logic               req_i, req_d;
  logic               grant_i, grant_d;
  logic               cap_i, cap_d;
  logic               last_d;
  logic               tmo;
  logic [TCNT_W-1:0]  tcnt;

  assign i_live = {i_instr, i_addr, i_wdata, i_wstrb};
  assign d_live = {d_instr, d_addr, d_wdata, d_wstrb};

  // A pending request always takes precedence over the live inputs, which are ignored until it is granted.
  assign i_sel = pend_i ? i_buf : i_live;
  assign d_sel = pend_d ? d_buf : d_live;
  assign req_i = pend_i | i_valid;
  assign req_d = pend_d | d_valid;

  // A port never captures while its own transaction is in flight or already buffered.
  assign cap_i = rst && i_valid && !pend_i && (state != BUSY_I) && !grant_i;
  assign cap_d = rst && d_valid && !pend_d && (state != BUSY_D) && !grant_d;

  assign tmo = WD_EN && (state != IDLE) && (tcnt == TLAST);

  assign {mem_instr, mem_addr, mem_wdata, mem_wstrb} = fwd;

  // Arbitrate in IDLE with same-cycle forwarding; in BUSY steer the response (or a timeout) to the owner.
  always_comb begin
    state_nxt   = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    fwd         = '0;
    mem_valid   = 1'b0;
    i_ready     = 1'b0;
    i_rdata     = '0;
    d_ready     = 1'b0;
    d_rdata     = '0;
    timeout_err = 1'b0;
    if (!rst) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_d && (!req_i || (RR_EN == 0) || !last_d)) begin
            grant_d   = 1'b1;
            fwd       = d_sel;
            mem_valid = 1'b1;
            state_nxt = BUSY_D;
          end else if (req_i) begin
            grant_i   = 1'b1;
            fwd       = i_sel;
            mem_valid = 1'b1;
            state_nxt = BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            i_ready   = 1'b1;
            i_rdata   = mem_rdata;
            state_nxt = IDLE;
          end else if (tmo) begin
            i_ready     = 1'b1;
            timeout_err = 1'b1;
            state_nxt   = IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            d_ready   = 1'b1;
            d_rdata   = mem_rdata;
            state_nxt = IDLE;
          end else if (tmo) begin
            d_ready     = 1'b1;
            timeout_err = 1'b1;
            state_nxt   = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Pending buffers and the round-robin history bit (0 = instruction port granted last).
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_i <= 1'b0;
      pend_d <= 1'b0;
      i_buf  <= '0;
      d_buf  <= '0;
      last_d <= 1'b0;
    end else begin
      if (grant_i) begin
        pend_i <= 1'b0;
      end else if (cap_i) begin
        pend_i <= 1'b1;
        i_buf  <= i_live;
      end
      if (grant_d) begin
        pend_d <= 1'b0;
      end else if (cap_d) begin
        pend_d <= 1'b1;
        d_buf  <= d_live;
      end
      if (grant_i)      last_d <= 1'b0;
      else if (grant_d) last_d <= 1'b1;
    end
  end

  // Watchdog counter: cleared on issue, counts BUSY cycles that see no response.
  always_ff @(posedge clk) begin
    if (!rst)                                       tcnt <= '0;
    else if (grant_i || grant_d)                    tcnt <= '0;
    else if (WD_EN && (state != IDLE) && !mem_ready) tcnt <= tcnt + 1'b1;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory slave (bram, uart or clint) between the CPU instruction and data request ports.
- Replaces the drop-on-conflict behaviour of per-slave steering: a losing request is buffered and issued later, never lost.
- Routes the single slave response back to the requester that owns the outstanding transaction.
- Adds a selectable fixed or round-robin policy and a response watchdog.

Parameters:
RR_EN, 0, 0 = fixed priority (data port wins); 1 = round-robin (the port not granted last wins)
TIMEOUT, 0, cycles in BUSY without mem_ready before a forced error response; 0 disables the watchdog
TCNT_W, 16, width of the watchdog counter; TIMEOUT must be < 2^TCNT_W

Ports:
rst  in  1  synchronous, active-low reset
clk  in  1  clock
i_valid  in  1  instruction request pulse (one cycle)
i_instr  in  1  request is an instruction fetch
i_addr  in  32  request address
i_wdata  in  32  write data
i_wstrb  in  4  byte write strobes; 0 = read
i_rdata  out  32  response data
i_ready  out  1  response pulse (one cycle)
d_valid, d_instr, d_addr, d_wdata, d_wstrb, d_rdata, d_ready: same as the i_* ports, for the data port
mem_valid  out  1  slave request pulse
mem_instr  out  1  forwarded instr flag
mem_addr  out  32  forwarded address
mem_wdata  out  32  forwarded write data
mem_wstrb  out  4  forwarded write strobes
mem_rdata  in  32  slave read data
mem_ready  in  1  slave response pulse; never in the same cycle as mem_valid
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Requester protocol:
  - Each port issues at most one request at a time; it raises valid again only after its own ready.
  - A valid on a port whose request is already pending or in flight is ignored.
- Pending buffers:
  - Per port: a pend flag plus registered instr/addr/wdata/wstrb.
  - A valid that is not granted in its arrival cycle is captured and sets pend.
  - pend clears in the cycle that request is granted.
- Request set per port: req_x = pend_x | x_valid. Fields come from the buffer when pend_x = 1, otherwise from the live inputs.
- FSM states: IDLE, BUSY_I, BUSY_D.
  - IDLE, no req: all mem_* = 0; stay in IDLE.
  - IDLE, any req: arbitrate. mem_valid = 1 in the same cycle with the winner's fields (zero-latency pass-through). Record the winner in last_grant. Go to BUSY_I or BUSY_D.
- Arbitration when both ports request:
  - RR_EN = 0: data wins.
  - RR_EN = 1: the port not equal to last_grant wins. last_grant resets to I, so the first contention grants D.
- BUSY_x:
  - mem_valid = 0 and mem_* fields = 0.
  - A new valid on the other port is captured into its buffer.
  - On mem_ready: x_ready = 1 and x_rdata = mem_rdata in the same cycle (combinational). Go to IDLE.
  - A pending request is therefore issued the cycle after the response, giving 1 idle cycle between back-to-back transactions.
- Response isolation:
  - The non-owning port always sees ready = 0 and rdata = 0.
  - mem_ready in IDLE is ignored.
- Watchdog, active when TIMEOUT > 0:
  - The counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT-1 with no mem_ready: x_ready = 1, x_rdata = 0, timeout_err = 1 for one cycle, go to IDLE.
  - A later stray mem_ready is ignored.
  - mem_ready in the final cycle wins over the timeout (normal response, no error).
- Simultaneous events:
  - mem_ready in BUSY_x together with a new valid on port y: the response is delivered and y is captured into pend_y.
  - i_valid and d_valid both arriving in IDLE: the winner is issued, the loser is captured.
- Reset (rst = 0 at a clk edge):
  - State IDLE, pend_i = pend_d = 0, buffers 0, last_grant = I, counter 0.
  - All outputs 0 from the cycle after reset: i_ready, d_ready, i_rdata, d_rdata, mem_valid, all mem_* fields, timeout_err.
  - A transaction in flight at reset is abandoned; its late mem_ready is ignored.

Test Plan:
- Single read, slave ready 2 cycles later: i_valid, i_addr = 0x100 -> mem_valid with mem_addr = 0x100 in the same cycle; i_ready with i_rdata = 0xDEADBEEF on the mem_ready cycle; d_ready stays 0.
- Contention, RR_EN = 0: i_valid (0x10) and d_valid (0x20) in the same cycle -> mem_addr = 0x20 first; 0x10 issued the cycle after d_ready; each port receives only its own data.
- RR_EN = 1, both ports hammering with back-to-back requests over 3 rounds -> grant order D, I, D, I, D, I; no request lost; 6 responses.
- Capture during BUSY_D: i_valid with i_wstrb = 0xF, i_wdata = 0x55 -> later issued with mem_wstrb = 0xF and mem_wdata = 0x55 unchanged from the buffer.
- TIMEOUT = 8, slave never responds -> d_ready = 1, d_rdata = 0 and timeout_err = 1 exactly 8 BUSY cycles after issue; a mem_ready injected afterwards produces no ready.
- Reset asserted during BUSY_I with pend_d = 1 -> all outputs 0; the late mem_ready is ignored; the next d_valid is issued in its arrival cycle.
